agmem_split_sequencer: RTL

- Sits directly downstream of the register-read/address-generation stage. It consumes that stage's mem_addr1 / mem_addr1_end / mem1_rw / opsize outputs.
- For read operands it issues 16-byte line requests to the D-cache over a valid/ready channel. An access that crosses a line boundary becomes two sequential requests.
- It assembles the operand bytes, right-justified, into a 64-bit result, handshakes it to the execute side, and back-pressures the address-generation stage while busy.

---
 rtl/agmem_split_sequencer_pkg.sv | 19 +
 rtl/agmem_byte_align.sv | 41 ++++
 rtl/agmem_split_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/agmem_split_sequencer_pkg.sv
// Shared definitions for the split-line operand sequencer: FSM encoding,
// default line size and mem_rw bit positions.
package agmem_split_sequencer_pkg;

    localparam int LINE_BYTES   = 16;
    localparam int RW_READ_BIT  = 0;
    localparam int RW_WRITE_BIT = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ0   = 3'd1,
        WAIT0  = 3'd2,
        REQ1   = 3'd3,
        WAIT1  = 3'd4,
        DONE   = 3'd5,
        BYPASS = 3'd6
    } state_t;

endpackage

// File: rtl/agmem_byte_align.sv
// Eight-lane byte selector: picks operand bytes from one or two cache lines,
// right-justified and zero-filled above the operand size.
module agmem_byte_align #(
    parameter int LINE_BYTES = 16
) (
    input  logic [8*LINE_BYTES-1:0]       buf0,
    input  logic [8*LINE_BYTES-1:0]       buf1,
    input  logic [$clog2(LINE_BYTES)-1:0] offset,
    input  logic [1:0]                    opsize,
    output logic [63:0]                   out_data
);
    import agmem_split_sequencer_pkg::*;

    localparam int OFF_W = $clog2(LINE_BYTES);

    logic [7:0] lane_en;

    always_comb begin
        lane_en = 8'hFF;
        case (opsize)
            2'd0:    lane_en = 8'h01;
            2'd1:    lane_en = 8'h03;
            2'd2:    lane_en = 8'h0F;
            default: lane_en = 8'hFF;
        endcase
    end

    // offset + lane never reaches 2*LINE_BYTES, so the carry bit selects buf1
    for (genvar k = 0; k < 8; k++) begin : g_lane
        localparam logic [OFF_W:0] LANE = k;
        logic [OFF_W:0] pos;
        logic [7:0]     byte0;
        logic [7:0]     byte1;

        assign pos   = {1'b0, offset} + LANE;
        assign byte0 = buf0[{pos[OFF_W-1:0], 3'b000} +: 8];
        assign byte1 = buf1[{pos[OFF_W-1:0], 3'b000} +: 8];
        assign out_data[8*k +: 8] = !lane_en[k] ? 8'h00 : (pos[OFF_W] ? byte1 : byte0);
    end

endmodule

// File: rtl/agmem_split_sequencer.sv
// Turns one read operand into one or two 16-byte line fetches and returns the
// assembled 64-bit operand; write-only and no-memory packets bypass the cache.
module agmem_split_sequencer #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = agmem_split_sequencer_pkg::LINE_BYTES,
    parameter int PTCID_W    = 7
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    valid_in,
    input  logic [ADDR_W-1:0]       mem_addr,
    input  logic [ADDR_W-1:0]       mem_addr_end,
    input  logic [1:0]              mem_rw,
    input  logic [1:0]              opsize,
    input  logic [PTCID_W-1:0]      ptcid_in,
    output logic                    stall_up,
    output logic                    req_valid,
    input  logic                    req_ready,
    output logic [ADDR_W-1:0]       req_addr,
    input  logic                    resp_valid,
    input  logic [8*LINE_BYTES-1:0] resp_line,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [63:0]             out_data,
    output logic                    out_split,
    output logic [PTCID_W-1:0]      out_ptcid,
    output logic [2:0]              dbg_state
);
    import agmem_split_sequencer_pkg::*;

    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int BASE_W = ADDR_W - OFF_W;
    localparam int LINE_W = 8 * LINE_BYTES;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready, and payload holds while valid waits.
    state_t              state;
    state_t              state_nx;
    logic [BASE_W-1:0]   base0_q;
    logic [BASE_W-1:0]   base1_q;
    logic [OFF_W-1:0]    off_q;
    logic [1:0]          opsize_q;
    logic                split_q;
    logic [PTCID_W-1:0]  ptcid_q;
    logic [LINE_W-1:0]   buf0_q;
    logic [LINE_W-1:0]   buf1_q;
    logic [LINE_W-1:0]   align_buf0;
    logic [LINE_W-1:0]   align_buf1;
    logic [63:0]         align_data;
    logic                accept;
    logic                split_in;
    logic                unused_bits;

    assign accept      = valid_in && (state == IDLE);
    assign split_in    = mem_addr[ADDR_W-1:OFF_W] != mem_addr_end[ADDR_W-1:OFF_W];
    assign dbg_state   = state;
    assign unused_bits = ^{mem_addr_end[OFF_W-1:0], mem_rw[RW_WRITE_BIT]};

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        req_valid = 1'b0;
        out_valid = 1'b0;
        stall_up  = (state != IDLE);
        case (state)
            IDLE:   if (valid_in) state_nx = mem_rw[RW_READ_BIT] ? REQ0 : BYPASS;
            REQ0: begin
                req_valid = 1'b1;
                if (req_ready) state_nx = WAIT0;
            end
            WAIT0:  if (resp_valid) state_nx = split_q ? REQ1 : DONE;
            REQ1: begin
                req_valid = 1'b1;
                if (req_ready) state_nx = WAIT1;
            end
            WAIT1:  if (resp_valid) state_nx = DONE;
            DONE, BYPASS: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign req_addr = {(state == REQ1) ? base1_q : base0_q, {OFF_W{1'b0}}};

    // The aligner sees the line arriving this cycle so the result can be
    // registered on the same edge that enters DONE.
    assign align_buf0 = (state == WAIT0) ? resp_line : buf0_q;
    assign align_buf1 = (state == WAIT1) ? resp_line : buf1_q;

    agmem_byte_align #(
        .LINE_BYTES (LINE_BYTES)
    ) u_align (
        .buf0     (align_buf0),
        .buf1     (align_buf1),
        .offset   (off_q),
        .opsize   (opsize_q),
        .out_data (align_data)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            base0_q   <= '0;
            base1_q   <= '0;
            off_q     <= '0;
            opsize_q  <= '0;
            split_q   <= 1'b0;
            ptcid_q   <= '0;
            buf0_q    <= '0;
            buf1_q    <= '0;
            out_data  <= '0;
            out_split <= 1'b0;
            out_ptcid <= '0;
        end else begin
            if (accept) begin
                base0_q  <= mem_addr[ADDR_W-1:OFF_W];
                base1_q  <= mem_addr_end[ADDR_W-1:OFF_W];
                off_q    <= mem_addr[OFF_W-1:0];
                opsize_q <= opsize;
                split_q  <= split_in;
                ptcid_q  <= ptcid_in;
            end
            if (state == WAIT0 && resp_valid) buf0_q <= resp_line;
            if (state == WAIT1 && resp_valid) buf1_q <= resp_line;
            if (state_nx == DONE && state != DONE) begin
                out_data  <= align_data;
                out_split <= split_q;
                out_ptcid <= ptcid_q;
            end else if (accept && !mem_rw[RW_READ_BIT]) begin
                out_data  <= '0;
                out_split <= 1'b0;
                out_ptcid <= ptcid_in;
            end
        end
    end

endmodule
